// File: rtl/bit_timer.sv
// Bit/byte timing generator for the serial receive path: one shift strobe per bit period, byte_done after each byte.
// Optional macro BIT_TIMER_RESYNC_EN: a data-line edge in RUN realigns the bit-period counter to zero.
module bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8,
  parameter int SAMPLE_OFFSET = 3,
  localparam int CW = $clog2(CLKS_PER_BIT),
  localparam int BW = $clog2(BITS_PER_BYTE + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic          edge_i,
  output logic          shift_strobe_o,
  output logic          byte_done_o,
  output logic [BW-1:0] bit_index_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            byte_done_q, byte_done_d;

  logic            strobe;
  logic            last_bit;
  logic [CW-1:0]   clk_cnt_inc;

  assign strobe      = (state_q == RUN) && (clk_cnt_q == CW'(SAMPLE_OFFSET));
  assign last_bit    = (bit_cnt_q == BW'(BITS_PER_BYTE - 1));
  assign clk_cnt_inc = (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : clk_cnt_q + CW'(1);

`ifndef BIT_TIMER_RESYNC_EN
  logic unused_edge;
  assign unused_edge = edge_i;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    if (clear_i) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_d   = RUN;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
          end
        end
        RUN: begin
          if (strobe) begin
            bit_cnt_d   = last_bit ? '0 : bit_cnt_q + BW'(1);
            byte_done_d = last_bit;
          end
          // A strobe taken while pausing moves the phase past the sample point so it is not repeated on resume.
          if (enable_i || strobe) clk_cnt_d = clk_cnt_inc;
          if (!enable_i) state_d = HOLD;
`ifdef BIT_TIMER_RESYNC_EN
          if (edge_i) clk_cnt_d = '0;
`endif
        end
        HOLD: begin
          if (enable_i) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!n_rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign shift_strobe_o = strobe;
  assign byte_done_o    = byte_done_q;
  assign bit_index_o    = bit_cnt_q;
  assign busy_o         = (state_q != IDLE);

endmodule
